// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: execute command encodings,
// field widths and the saturating bubble-counter increment.
package id_ex_stage_reg_pkg;

    localparam int EXECUTE_COMMAND_LEN = 4;
    localparam int ID_EX_BUBBLE_CNT_W  = 16;
    localparam int SHIFT_OPERAND_W     = 12;
    localparam int SIGNED_IMM24_W      = 24;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    typedef enum logic [EXECUTE_COMMAND_LEN-1:0] {
        EXEC_NOP = 4'b0000,
        EXEC_MOV = 4'b0001,
        EXEC_ADD = 4'b0010,
        EXEC_ADC = 4'b0011,
        EXEC_SUB = 4'b0100,
        EXEC_SBC = 4'b0101,
        EXEC_AND = 4'b0110,
        EXEC_ORR = 4'b0111,
        EXEC_EOR = 4'b1000,
        EXEC_MVN = 4'b1001
    } exec_cmd_e;

    // Saturates at all-ones instead of wrapping.
    function automatic logic [ID_EX_BUBBLE_CNT_W-1:0] bubble_sat_inc(
        input logic [ID_EX_BUBBLE_CNT_W-1:0] cnt
    );
        if (&cnt) return cnt;
        return cnt + {{(ID_EX_BUBBLE_CNT_W-1){ZERO}}, ONE};
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_pipe_field_reg.sv
// Generic pipeline field register: reset > clear > hold > load, with a
// configurable value used for both reset and clear.
module pipe_field_reg #(
    parameter int         W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            q_d = CLR_VAL;
        end else if (!hold_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= CLR_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush and bubble gating of control bits.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int EXEC_CMD_W = EXECUTE_COMMAND_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       wb_en_in,
    input  logic                       mem_read_in,
    input  logic                       mem_write_in,
    input  logic                       branch_in,
    input  logic                       s_in,
    input  logic [EXEC_CMD_W-1:0]      exec_cmd_in,
    input  logic [DATA_W-1:0]          val_rn_in,
    input  logic [DATA_W-1:0]          val_rm_in,
    input  logic                       imm_in,
    input  logic [SHIFT_OPERAND_W-1:0] shift_operand_in,
    input  logic [SIGNED_IMM24_W-1:0]  signed_imm24_in,
    input  logic [REG_ADDR_W-1:0]      dest_in,
    input  logic [REG_ADDR_W-1:0]      src1_in,
    input  logic [REG_ADDR_W-1:0]      src2_in,
    input  logic                       carry_in,
    output logic                       valid_out,
    output logic [DATA_W-1:0]          pc_out,
    output logic                       wb_en_out,
    output logic                       mem_read_out,
    output logic                       mem_write_out,
    output logic                       branch_out,
    output logic                       s_out,
    output logic [EXEC_CMD_W-1:0]      exec_cmd_out,
    output logic [DATA_W-1:0]          val_rn_out,
    output logic [DATA_W-1:0]          val_rm_out,
    output logic                       imm_out,
    output logic [SHIFT_OPERAND_W-1:0] shift_operand_out,
    output logic [SIGNED_IMM24_W-1:0]  signed_imm24_out,
    output logic [REG_ADDR_W-1:0]      dest_out,
    output logic [REG_ADDR_W-1:0]      src1_out,
    output logic [REG_ADDR_W-1:0]      src2_out,
    output logic                       carry_out
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [ID_EX_BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

    localparam int CTRL_W = 6 + EXEC_CMD_W;
    localparam int OPND_W = 3 * DATA_W + 1;
    localparam int IMM_W  = 1 + SHIFT_OPERAND_W + SIGNED_IMM24_W;
    localparam int IDX_W  = 3 * REG_ADDR_W;

    logic [4:0]        ctrl_flags;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [OPND_W-1:0] opnd_d, opnd_q;
    logic [IMM_W-1:0]  imm_d,  imm_q;
    logic [IDX_W-1:0]  idx_d,  idx_q;

    // A bubble never carries side-effecting control, whatever decode drove.
    assign ctrl_flags = (in_valid == ONE)
                      ? {wb_en_in, mem_read_in, mem_write_in, branch_in, s_in}
                      : {5{ZERO}};

    assign ctrl_d = {in_valid, ctrl_flags, exec_cmd_in};
    assign opnd_d = {pc_in, val_rn_in, val_rm_in, carry_in};
    assign imm_d  = {imm_in, shift_operand_in, signed_imm24_in};
    assign idx_d  = {dest_in, src1_in, src2_in};

    pipe_field_reg #(.W(CTRL_W), .CLR_VAL('0)) u_ctrl_reg (
        .clk(clk), .rst(rst), .clear_i(flush), .hold_i(freeze),
        .d_i(ctrl_d), .q_o(ctrl_q)
    );

    pipe_field_reg #(.W(OPND_W), .CLR_VAL('0)) u_opnd_reg (
        .clk(clk), .rst(rst), .clear_i(flush), .hold_i(freeze),
        .d_i(opnd_d), .q_o(opnd_q)
    );

    pipe_field_reg #(.W(IMM_W), .CLR_VAL('0)) u_imm_reg (
        .clk(clk), .rst(rst), .clear_i(flush), .hold_i(freeze),
        .d_i(imm_d), .q_o(imm_q)
    );

    pipe_field_reg #(.W(IDX_W), .CLR_VAL('0)) u_idx_reg (
        .clk(clk), .rst(rst), .clear_i(flush), .hold_i(freeze),
        .d_i(idx_d), .q_o(idx_q)
    );

    assign {valid_out, wb_en_out, mem_read_out, mem_write_out,
            branch_out, s_out, exec_cmd_out}                   = ctrl_q;
    assign {pc_out, val_rn_out, val_rm_out, carry_out}         = opnd_q;
    assign {imm_out, shift_operand_out, signed_imm24_out}      = imm_q;
    assign {dest_out, src1_out, src2_out}                      = idx_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [ID_EX_BUBBLE_CNT_W-1:0] bubble_cnt_q;
    logic [ID_EX_BUBBLE_CNT_W-1:0] bubble_cnt_d;

    // A flush counts even when frozen; a frozen invalid slot is not a new bubble.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush || (!freeze && !in_valid)) begin
            bubble_cnt_d = bubble_sat_inc(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
